// File: rtl/mult_seq_mnbit.sv
// Sequential radix-2 shift-add multiplier with signed/unsigned mode.
// Consumes one multiplier bit per cycle on a single (M+1)-bit adder/subtractor.
// Operands are accepted through a valid/ready handshake, and the result is
// returned through a valid/ready handshake that the consumer can stall.
module mult_seq_mnbit #(
  parameter int unsigned M = 8,
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] prod,
  output logic           busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = M + N;
  localparam int unsigned HW = M + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [M-1:0]    r_a;
  logic            r_signed;
  logic [HW-1:0]   r_hi;
  logic [N-1:0]    r_lo;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_prod;
  logic            r_out_valid;
  logic            r_in_ready;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [M-1:0]    w_a_nxt;
  logic            w_signed_nxt;
  logic [HW-1:0]   w_hi_nxt;
  logic [N-1:0]    w_lo_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [PW-1:0]   w_prod_nxt;
  logic            w_out_valid_nxt;

  logic [HW-1:0]   w_a_ext;
  logic            w_last;
  logic [HW-1:0]   w_sum;
  logic            w_fill;

  // Partial-product step: add (or subtract on the signed MSB step) the extended multiplicand
  always_comb begin
    w_a_ext = r_signed ? {r_a[M-1], r_a} : {1'b0, r_a};
    w_last  = (r_cnt == CW'(N - 1));
    w_sum   = r_hi;
    if (r_lo[0]) begin
      if (r_signed && w_last) begin
        w_sum = r_hi - w_a_ext;
      end else begin
        w_sum = r_hi + w_a_ext;
      end
    end
    w_fill = r_signed & w_sum[M];
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_signed_nxt    = r_signed;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_cnt_nxt       = r_cnt;
    w_prod_nxt      = r_prod;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_a_nxt      = a;
          w_signed_nxt = signed_mode;
          w_hi_nxt     = '0;
          w_lo_nxt     = b;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_CALC;
        end
      end
      S_CALC: begin
        // Shift the accumulator right; the low half doubles as the multiplier shifter
        w_hi_nxt  = {w_fill, w_sum[M:1]};
        w_lo_nxt  = {w_sum[0], r_lo[N-1:1]};
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last) begin
          w_prod_nxt      = {w_sum, r_lo[N-1:1]};
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_signed    <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_signed    <= w_signed_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_cnt       <= w_cnt_nxt;
      r_prod      <= w_prod_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt == S_CALC) || (w_state_nxt == S_DONE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign prod      = r_prod;
  assign busy      = r_busy;

endmodule

// File: doc/mult_seq_mnbit.md
Name: mult_seq_mnbit

Overview:
- Sequential radix-2 shift-add multiplier: M-bit multiplicand by N-bit multiplier, full (M+N)-bit product.
- Successor to the combinational array multiplier. Trades area for latency: one multiplier bit per cycle on a single M+1-bit adder.
- Adds a per-operation signed/unsigned mode and valid/ready handshakes on both input and output.
- Sits between operand-producing datapath stages and result consumers that may apply backpressure.

Parameters:
- M, 8, multiplicand (a) width in bits; legal range M >= 2.
- N, 8, multiplier (b) width in bits; legal range N >= 2; also the number of iteration cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  M  multiplicand.
- b  input  N  multiplier.
- signed_mode  input  1  1 = two's-complement a and b; 0 = unsigned.
- out_valid  output  1  prod holds a completed result.
- out_ready  input  1  consumer accepts the result.
- prod  output  M+N  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE; the in-flight operation is discarded with no output.
  - out_valid=0, prod=0, busy=0, iteration counter=0.
  - in_ready=1 while rst is deasserted, since the FSM is in IDLE.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1: latch a, b and signed_mode into internal registers; clear the accumulator; counter=0; go to CALC.
  - in_valid=0: stay in IDLE.
- CALC:
  - Runs exactly N cycles, counter 0..N-1.
  - Cycle k examines latched b bit k; when set, the adder adds the multiplicand (sign-extended to M+1 bits in signed mode, zero-extended otherwise) into the upper accumulator.
  - The accumulator then shifts right by one, arithmetic in signed mode and logical otherwise.
  - Last step (k=N-1): in signed mode with b[N-1]=1, the multiplicand is subtracted instead of added (two's-complement weight of the MSB).
  - On the edge ending k=N-1: prod is registered from the accumulator, out_valid is set, and the FSM goes to DONE.
  - Inputs a, b, signed_mode and in_valid are ignored throughout CALC.
- DONE:
  - out_valid=1; prod holds stable.
  - On an edge with out_ready=1: clear out_valid and go to IDLE. prod keeps its value, but it is meaningful only while out_valid=1.
  - out_ready=0: stay in DONE indefinitely, with no loss or change of prod.
- Latency: acceptance edge at cycle t gives out_valid=1 after edge t+N. Minimum initiation interval is N+2 cycles (accept, N iterations, handshake).
- Back-to-back:
  - in_ready returns high the cycle after the output handshake.
  - No overlap of input acceptance with DONE.
- Arithmetic:
  - Result is exact in (M+N) bits for all operand values in both modes. No overflow is possible.
  - Signed extremes are covered: (-2^(M-1)) * (-2^(N-1)) = 2^(M+N-2), positive, fits.
  - Unsigned max: (2^M-1)(2^N-1).
  - Zero operands produce 0 with identical latency (no early termination).
- Out of scope: out_ready while out_valid=0 is ignored. in_valid is not required to be held after acceptance.

Test Plan:
- M=N=8 unsigned, a=0xFF, b=0xFF, out_ready=1 -> prod=0xFE01. out_valid rises exactly 8 edges after acceptance and stays high 1 cycle. in_ready=1 next cycle.
- M=N=8 signed:
  - a=0x80, b=0x80 -> prod=0x4000.
  - a=0xFF, b=0x01 -> prod=0xFFFF.
  - a=0x7F, b=0x80 -> prod=0xC080.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; toggle a/b/in_valid meanwhile -> prod constant, in_ready=0, busy=1. Handshake completes on the first edge with out_ready=1.
- Assert rst asynchronously at CALC iteration 3 -> out_valid=0, prod=0, busy=0 immediately. After release, a new operation (unsigned 3*5) yields prod=15 with no residue.
- M=4, N=6:
  - Unsigned 15*63 -> prod=945 (10'h3B1).
  - Signed a=4'h8, b=6'h20 (-8 * -32) -> prod=256.
  - Signed a=4'h7, b=6'h3F (7 * -1) -> prod=10'h3F9.
  - Latency 6 cycles in each case.
- Randomised sweep of 2000 operations, random mode and random out_ready stalls, compared against a reference product -> zero mismatches, one result per accepted operation, order preserved.
